// File: rtl/grf_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : grf_pkg
//  Description : Shared defaults and helpers for the general register file
//                with pending-write scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
package grf_pkg;

  localparam int DW_DEF   = 32;    // default data width
  localparam int AW_DEF   = 5;     // default register address width
  localparam int REG_ZERO = 0;     // hardwired-zero register index
  localparam int POP_MAX  = 1024;  // widest busy vector popcount accepts

  // Number of set bits in a zero-extended busy vector.
  function automatic int unsigned popcount(input logic [POP_MAX-1:0] vec);
    int unsigned n;
    n = 0;
    for (int i = 0; i < POP_MAX; i++) begin
      n += {31'b0, vec[i]};
    end
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/grf_read_port.sv
`default_nettype none
// ============================================================================
//  Module      : grf_read_port
//  Description : One combinational register-file read port with optional
//                write-back forwarding and pending-write (busy) indication.
//  Revision    : 1.0 - initial release
// ============================================================================
module grf_read_port
  import grf_pkg::*;
#(
  parameter int DW     = DW_DEF,
  parameter int AW     = AW_DEF,
  parameter int BYPASS = 1
) (
  input  logic [AW-1:0]     addr,
  input  logic [DW-1:0]     regs [2**AW],
  input  logic [2**AW-1:0]  busy_vec,
  input  logic              we,
  input  logic [AW-1:0]     wa,
  input  logic [DW-1:0]     wd,
  output logic [DW-1:0]     data,
  output logic              busy
);

  localparam logic BYP = (BYPASS != 0);

  logic wa_match;
  logic fwd_hit;

  assign wa_match = we && (wa == addr);
  // A write to register 0 is discarded, so it must never be forwarded.
  assign fwd_hit  = BYP && wa_match && (wa != AW'(REG_ZERO));

  // Forwarded write-back data wins over the stored value; index is full range.
  always_comb begin
    data = fwd_hit ? wd : regs[addr];
  end

  // A write completing this cycle is forwarded, so the hazard is already gone.
  always_comb begin
    busy = busy_vec[addr] & ~(BYP & wa_match);
  end

endmodule
`default_nettype wire

// File: rtl/grf_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : grf_scoreboard
//  Description : Parametrised general register file with NRD read ports,
//                write-to-read bypass and a per-register pending-write
//                scoreboard with a registered outstanding-write count.
//  Revision    : 1.0 - initial release
// ============================================================================
module grf_scoreboard
  import grf_pkg::*;
#(
  parameter int DW     = DW_DEF,
  parameter int AW     = AW_DEF,
  parameter int NRD    = 2,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*DW-1:0] rd_data,
  output logic [NRD-1:0]    rd_busy,
  input  logic              we,
  input  logic [AW-1:0]     wa,
  input  logic [DW-1:0]     wd,
  input  logic              iss_valid,
  input  logic [AW-1:0]     iss_addr,
  input  logic              flush,
  output logic [AW:0]       pend_cnt
);

  localparam int NREG = 2**AW;

  if (NRD < 1 || NRD > 4) begin : g_bad_nrd
    $error("grf_scoreboard: NRD must be in 1..4");
  end
  if (NREG > POP_MAX) begin : g_bad_aw
    $error("grf_scoreboard: AW too large for popcount helper");
  end

  logic [DW-1:0]      regs [NREG];
  logic [NREG-1:0]    busy;
  logic [NREG-1:0]    busy_nxt;
  logic [POP_MAX-1:0] pop_vec;

  // Register storage; register 0 is never written and stays at its reset zero.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      for (int r = 0; r < NREG; r++) begin
        regs[r] <= '0;
      end
    end else if (we && (wa != AW'(REG_ZERO))) begin
      regs[wa] <= wd;
    end
  end

  // Scoreboard next state: flush clears all, a new issue beats a same-cycle WB clear.
  always_comb begin
    busy_nxt = busy;
    for (int r = 1; r < NREG; r++) begin
      if (flush) begin
        busy_nxt[r] = 1'b0;
      end else if (iss_valid && (iss_addr == AW'(r))) begin
        busy_nxt[r] = 1'b1;
      end else if (we && (wa == AW'(r))) begin
        busy_nxt[r] = 1'b0;
      end
    end
    busy_nxt[REG_ZERO] = 1'b0;
  end

  // Zero-extend the next-state vector to the popcount helper's width.
  always_comb begin
    pop_vec              = '0;
    pop_vec[NREG-1:0]    = busy_nxt;
  end

  // Busy bits and their count are updated together so the count never lags.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      busy     <= '0;
      pend_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      pend_cnt <= (AW+1)'(popcount(pop_vec));
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd_port
    grf_read_port #(
      .DW     (DW),
      .AW     (AW),
      .BYPASS (BYPASS)
    ) u_port (
      .addr     (rd_addr[k*AW +: AW]),
      .regs     (regs),
      .busy_vec (busy),
      .we       (we),
      .wa       (wa),
      .wd       (wd),
      .data     (rd_data[k*DW +: DW]),
      .busy     (rd_busy[k])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_grf_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : tb_grf_scoreboard
//  Description : Self-checking bench for grf_scoreboard: a 4-port bypassing
//                instance and a 1-port non-bypassing instance share stimulus
//                and are compared against a behavioural register/busy model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_grf_scoreboard;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 32;

  logic           clk = 1'b0;
  logic           clr_n;
  logic [4*AW-1:0] rd_addr;
  logic [4*DW-1:0] rd_data;
  logic [3:0]     rd_busy;
  logic           we;
  logic [AW-1:0]  wa;
  logic [DW-1:0]  wd;
  logic           iss_valid;
  logic [AW-1:0]  iss_addr;
  logic           flush;
  logic [AW:0]    pend_cnt;
  logic [DW-1:0]  nb_data;
  logic [0:0]     nb_busy;
  logic [AW:0]    nb_pend;

  grf_scoreboard #(.DW(DW), .AW(AW), .NRD(4), .BYPASS(1)) dut (
    .clk(clk), .clr_n(clr_n), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_busy(rd_busy), .we(we), .wa(wa), .wd(wd), .iss_valid(iss_valid),
    .iss_addr(iss_addr), .flush(flush), .pend_cnt(pend_cnt)
  );

  grf_scoreboard #(.DW(DW), .AW(AW), .NRD(1), .BYPASS(0)) dut_nb (
    .clk(clk), .clr_n(clr_n), .rd_addr(rd_addr[AW-1:0]), .rd_data(nb_data),
    .rd_busy(nb_busy), .we(we), .wa(wa), .wd(wd), .iss_valid(iss_valid),
    .iss_addr(iss_addr), .flush(flush), .pend_cnt(nb_pend)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int misses  = 0;

  logic [DW-1:0] m_regs [NR];
  bit            m_busy [NR];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      misses++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NR; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
  endfunction

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < NR; i++) n += int'(m_busy[i]);
    return n;
  endfunction

  // What a read of address a should return under the current inputs.
  function automatic logic [31:0] exp_data(input int a, input bit byp);
    if (byp && we && (int'(wa) == a) && a != 0) return wd;
    return m_regs[a];
  endfunction

  function automatic logic [31:0] exp_busy(input int a, input bit byp);
    if (byp && we && (int'(wa) == a)) return 32'd0;
    return {31'b0, m_busy[a]};
  endfunction

  // Apply one clock edge's effect on the architectural state.
  function automatic void model_edge();
    if (we && wa != 0) m_regs[wa] = wd;
    if (we) m_busy[wa] = 1'b0;
    if (iss_valid && iss_addr != 0) m_busy[iss_addr] = 1'b1;
    if (flush) for (int i = 0; i < NR; i++) m_busy[i] = 1'b0;
    m_busy[0] = 1'b0;
  endfunction

  task automatic check_outputs();
    for (int k = 0; k < 4; k++) begin
      int a;
      a = int'(rd_addr[k*AW +: AW]);
      chk($sformatf("rd_data%0d", k), rd_data[k*DW +: DW], exp_data(a, 1'b1));
      chk($sformatf("rd_busy%0d", k), {31'b0, rd_busy[k]}, exp_busy(a, 1'b1));
    end
    chk("pend_cnt", {26'b0, pend_cnt}, 32'(m_count()));
    chk("nb_rd_data", nb_data, exp_data(int'(rd_addr[AW-1:0]), 1'b0));
    chk("nb_rd_busy", {31'b0, nb_busy}, exp_busy(int'(rd_addr[AW-1:0]), 1'b0));
    chk("nb_pend_cnt", {26'b0, nb_pend}, 32'(m_count()));
  endtask

  task automatic settle();
    #1;
    check_outputs();
  endtask

  task automatic step_edge();
    @(posedge clk);
    if (clr_n) model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    we = 1'b0; wa = '0; wd = '0; iss_valid = 1'b0; iss_addr = '0; flush = 1'b0;
  endtask

  task automatic randomize_inputs();
    we        = 1'($urandom_range(0, 1));
    wa        = AW'($urandom_range(0, NR-1));
    wd        = $urandom;
    iss_valid = 1'($urandom_range(0, 1));
    iss_addr  = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, NR-1));
    flush     = ($urandom_range(0, 7) == 0);
    for (int k = 0; k < 4; k++) begin
      rd_addr[k*AW +: AW] = ($urandom_range(0, 1) == 1) ? wa : AW'($urandom_range(0, NR-1));
    end
  endtask

  initial begin
    clr_n   = 1'b0;
    rd_addr = '0;
    idle();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    settle();
    clr_n = 1'b1;

    // Register 0 ignores writes.
    we = 1'b1; wa = 5'd0; wd = 32'hFFFF_FFFF;
    settle();
    chk("zero_during_write", rd_data[31:0], 32'd0);
    step_edge();
    idle();
    settle();
    chk("zero_after_write", rd_data[31:0], 32'd0);
    step_edge();

    // Same-cycle bypass, then stored value.
    we = 1'b1; wa = 5'd3; wd = 32'h1234_5678; rd_addr[AW-1:0] = 5'd3;
    settle();
    chk("bypass_same_cycle", rd_data[31:0], 32'h1234_5678);
    chk("nobypass_same_cycle", nb_data, 32'd0);
    step_edge();
    idle();
    settle();
    chk("stored_next_cycle", rd_data[31:0], 32'h1234_5678);
    chk("nb_stored_next_cycle", nb_data, 32'h1234_5678);
    step_edge();

    // Scoreboard set then clear by write-back.
    iss_valid = 1'b1; iss_addr = 5'd5; rd_addr[AW-1:0] = 5'd5;
    settle();
    step_edge();
    idle();
    settle();
    chk("busy5_set", {31'b0, rd_busy[0]}, 32'd1);
    chk("pend_one", {26'b0, pend_cnt}, 32'd1);
    step_edge();
    we = 1'b1; wa = 5'd5; wd = 32'h0000_0055;
    settle();
    chk("busy5_bypassed", {31'b0, rd_busy[0]}, 32'd0);
    chk("nb_busy5_still", {31'b0, nb_busy}, 32'd1);
    step_edge();
    idle();
    settle();
    chk("pend_zero_after_wb", {26'b0, pend_cnt}, 32'd0);
    step_edge();

    // Issue and write-back to the same register in one cycle.
    iss_valid = 1'b1; iss_addr = 5'd7;
    settle();
    step_edge();
    we = 1'b1; wa = 5'd7; wd = 32'd9; iss_valid = 1'b1; iss_addr = 5'd7;
    settle();
    step_edge();
    idle(); rd_addr[AW-1:0] = 5'd7;
    settle();
    chk("reg7_value", rd_data[31:0], 32'd9);
    chk("busy7_kept", {31'b0, rd_busy[0]}, 32'd1);
    chk("pend_kept", {26'b0, pend_cnt}, 32'd1);
    we = 1'b1; wa = 5'd7; wd = 32'd9;
    settle();
    step_edge();

    // Flush beats a same-cycle issue.
    for (int r = 2; r <= 6; r += 2) begin
      idle(); iss_valid = 1'b1; iss_addr = AW'(r);
      settle();
      step_edge();
    end
    idle();
    settle();
    chk("pend_three", {26'b0, pend_cnt}, 32'd3);
    flush = 1'b1; iss_valid = 1'b1; iss_addr = 5'd8;
    settle();
    step_edge();
    idle(); rd_addr[AW-1:0] = 5'd8;
    settle();
    chk("busy8_dropped", {31'b0, rd_busy[0]}, 32'd0);
    chk("pend_flushed", {26'b0, pend_cnt}, 32'd0);
    step_edge();

    // Aliased ports and distinct ports.
    we = 1'b1; wa = 5'd10; wd = 32'h0000_A5A5;
    settle();
    step_edge();
    for (int r = 1; r <= 4; r++) begin
      we = 1'b1; wa = AW'(r); wd = 32'h1111_0000 * r;
      settle();
      step_edge();
    end
    idle(); rd_addr = {4{5'd10}};
    settle();
    for (int k = 0; k < 4; k++) chk($sformatf("alias%0d", k), rd_data[k*DW +: DW], 32'h0000_A5A5);
    rd_addr = {5'd4, 5'd3, 5'd2, 5'd1};
    settle();
    for (int k = 0; k < 4; k++) chk($sformatf("distinct%0d", k), rd_data[k*DW +: DW], 32'h1111_0000 * (k + 1));
    step_edge();

    // Randomised traffic.
    for (int n = 0; n < 400; n++) begin
      randomize_inputs();
      settle();
      step_edge();
    end

    // Asynchronous reset mid-cycle, held across an edge with a write pending.
    idle();
    #2 clr_n = 1'b0;
    model_reset();
    settle();
    we = 1'b1; wa = 5'd12; wd = 32'hDEAD_BEEF;
    step_edge();
    idle();
    for (int k = 0; k < 4; k++) rd_addr[k*AW +: AW] = AW'(12 + k);
    settle();
    chk("reset_reg12", rd_data[31:0], 32'd0);
    clr_n = 1'b1;
    settle();

    for (int n = 0; n < 200; n++) begin
      randomize_inputs();
      settle();
      step_edge();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end

  // Hard bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/grf_scoreboard.md
Name: grf_scoreboard

Overview:
- Parametrised successor to the pipeline's general register file (GRF).
- Adds a configurable number of combinational read ports, write-to-read bypass, and a per-register pending-write scoreboard.
- The scoreboard gives decode-stage hazard detection and a registered count of outstanding writes.
- Sits between ID (reads, issue marking) and WB (write-back); register 0 is hardwired to zero.

Parameters:
- DW, 32, data width in bits.
- AW, 5, register address width; NREG = 2**AW registers.
- NRD, 2, number of read ports (1..4).
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads return stored value only.

Ports:
- clk  in  1  clock, rising edge.
- clr_n  in  1  asynchronous active-low reset.
- rd_addr  in  NRD*AW  packed read addresses; port k = bits [k*AW +: AW].
- rd_data  out  NRD*DW  packed read data, combinational.
- rd_busy  out  NRD  per-port: addressed register has a pending write.
- we  in  1  write-back enable.
- wa  in  AW  write-back address.
- wd  in  DW  write-back data.
- iss_valid  in  1  instruction issued that will write iss_addr.
- iss_addr  in  AW  destination of issued instruction.
- flush  in  1  squash all in-flight producers; clears scoreboard.
- pend_cnt  out  AW+1  registered number of set scoreboard bits.

Behaviour:
- Reset: clr_n low asynchronously clears all NREG data registers, all busy bits and pend_cnt to 0. Reset asserted mid-operation discards everything; no write completes in that cycle.
- Register 0: always reads 0. Writes with wa==0 are ignored. Issue with iss_addr==0 never sets busy[0]. rd_busy is always 0 for address 0.
- Write: on rising clk, with we=1 and wa!=0, regs[wa] <= wd. The stored value is visible next cycle.
- Read port k, in priority order:
  - If BYPASS=1 and we and wa==rd_addr_k and wa!=0, rd_data_k = wd.
  - Otherwise rd_data_k = regs[rd_addr_k].
  - Reads are zero-latency combinational. All ports are independent and may alias the same address.
- rd_busy_k = busy[rd_addr_k] & ~(we & wa==rd_addr_k), when BYPASS=1. The pending write completes this cycle and its data is bypassed. When BYPASS=0, rd_busy_k = busy[rd_addr_k].
- Scoreboard next-state per register r (r!=0), evaluated at each rising edge:
  - flush=1: busy[r] <= 0 for all r. A same-cycle iss_valid is dropped. The WB write to regs still happens.
  - else if iss_valid and iss_addr==r: busy[r] <= 1. Issue wins over a same-cycle clear to the same r, because the newer producer supersedes.
  - else if we and wa==r: busy[r] <= 0.
  - else: hold.
- A WB to a register that is not busy still writes data; busy stays 0.
- pend_cnt is the registered popcount of the next-state busy vector. It equals the number of set bits one cycle after any change. Range 0..NREG-1, so it never overflows AW+1 bits.
- No X propagation: all read muxes are fully decoded. Out-of-range parameters (NRD<1) are a compile-time error via generate check.

Decomposition:
- Shared package grf_pkg holds:
  - the DW/AW defaults;
  - a REG_ZERO = 0 constant;
  - a function popcount(vector) used for pend_cnt.
- One natural sub-module, grf_read_port: a single read mux with bypass and busy logic, instantiated NRD times in a generate loop.
- Storage and scoreboard stay in the top module.

Test Plan:
- Reset and zero register:
  - Assert clr_n=0 mid-run, then release → all rd_data=0, rd_busy=0, pend_cnt=0.
  - we=1, wa=0, wd=32'hFFFF_FFFF, then read addr 0 → 0.
- Write/read and bypass:
  - we=1, wa=3, wd=32'h1234_5678 with rd_addr0=3 in the same cycle → rd_data0=32'h1234_5678 combinationally (BYPASS=1).
  - Next cycle with we=0 → still 32'h1234_5678.
  - With BYPASS=0 the same-cycle read returns the old value 0.
- Scoreboard set/clear:
  - iss_valid, iss_addr=5 → next cycle rd_busy for addr 5 = 1, pend_cnt=1.
  - WB we=1, wa=5 → rd_busy drops to 0 in that same cycle (bypass); after the edge pend_cnt=0.
- Simultaneous issue and WB to the same register:
  - busy[7]=1; one cycle with iss_valid, iss_addr=7 and we, wa=7, wd=9 → regs[7]=9, busy[7] stays 1, pend_cnt unchanged.
- Flush:
  - Set busy on registers 2, 4 and 6 (pend_cnt=3).
  - One cycle with flush=1 plus iss_valid, iss_addr=8 → all busy=0, busy[8]=0, pend_cnt=0.
- Multi-port aliasing (NRD=4):
  - All four rd_addr=10 and regs[10]=32'hA5A5 → all four rd_data=32'hA5A5 and identical rd_busy.
  - Distinct addresses 1..4 return their four distinct preloaded values.
